// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq
//
// Sequential packed-BCD to binary converter. It handles one digit per clock,
// most significant digit first, using acc = acc*10 + digit. The x10 step is
// built from shifts and one add, so no multiplier is needed.
//
// Parameters
//   NDIG      number of packed BCD digits per request (1..9)
//   BW        binary result width, at least ceil(log2(10^NDIG))
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   start     request pulse; only sampled while idle
//   bcd       packed BCD operand; digit 0 is in bits [3:0]
//   busy      high while converting and during the result cycle
//   bin       binary result; stays stable until the next accepted request
//   bin_valid one-cycle pulse that marks a new result on bin
//   err       qualified by bin_valid; set when any digit was greater than 9
module bcd_to_bin_seq #(
    parameter int NDIG = 4,
    parameter int BW   = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NDIG-1:0] bcd,
    output logic              busy,
    output logic [BW-1:0]     bin,
    output logic              bin_valid,
    output logic              err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [1:0]        state;
    logic [4*NDIG-1:0] operand;
    logic [BW-1:0]     acc;
    logic [CW-1:0]     cnt;
    logic              err_f;

    logic [3:0]        digit;
    logic [BW+3:0]     sum;
    logic [BW-1:0]     acc_next;
    logic              err_next;

    // The operand shifts left once per digit, so the digit being processed
    // is always in the top nibble.
    assign digit    = operand[4*NDIG-1 -: 4];
    assign sum      = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1)
                    + {{BW{1'b0}}, digit};
    assign acc_next = BW'(sum);
    assign err_next = err_f | (digit > 4'd9);

    assign busy      = (state != IDLE);
    assign bin_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            operand <= '0;
            acc     <= '0;
            cnt     <= '0;
            err_f   <= 1'b0;
            bin     <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        operand <= bcd;
                        acc     <= '0;
                        err_f   <= 1'b0;
                        cnt     <= CW'(NDIG - 1);
                        state   <= CONV;
                    end
                end
                CONV: begin
                    acc     <= acc_next;
                    operand <= operand << 4;
                    err_f   <= err_next;
                    cnt     <= cnt - 1'b1;
                    if (cnt == '0) begin
                        // The last digit's error contribution has to be
                        // folded in here, before err_f registers it.
                        state <= DONE;
                        bin   <= err_next ? '0 : acc_next;
                        err   <= err_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq
//
// Bench for bcd_to_bin_seq. It drives directed vectors into a 4-digit
// instance and a 1-digit instance. A transaction-level reference model
// supplies the expected outputs, and a per-cycle compare process checks the
// DUT against it. Hand-computed literal expectations pin the directed cases.
module tb_bcd_to_bin_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bcd = '0;
    logic        busy;
    logic [13:0] bin;
    logic        bin_valid;
    logic        err;

    logic        s_start = 1'b0;
    logic [3:0]  s_bcd = '0;
    logic        s_busy;
    logic [3:0]  s_bin;
    logic        s_bin_valid;
    logic        s_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_to_bin_seq #(.NDIG(4), .BW(14)) dut (
        .clk(clk), .rst(rst), .start(start), .bcd(bcd),
        .busy(busy), .bin(bin), .bin_valid(bin_valid), .err(err)
    );

    bcd_to_bin_seq #(.NDIG(1), .BW(4)) dut1 (
        .clk(clk), .rst(rst), .start(s_start), .bcd(s_bcd),
        .busy(s_busy), .bin(s_bin), .bin_valid(s_bin_valid), .err(s_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal reading of a 4-digit packed operand: {err, value mod 2^14}.
    function automatic logic [14:0] ref_conv(input logic [15:0] v);
        int unsigned val;
        logic e;
        int unsigned d;
        val = 0;
        e = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            d = (32'(v) >> (4 * i)) & 32'hF;
            if (d > 9) e = 1'b1;
            val = val * 10 + d;
        end
        return {e, e ? 14'd0 : val[13:0]};
    endfunction

    // Transaction model. An accepted request makes the block busy for NDIG+1
    // cycles. The result appears in the last of those cycles.
    int          m_left = 0;
    logic [13:0] m_bin = '0;
    logic        m_err = 1'b0;
    logic [14:0] m_pend = '0;
    int          cyc = 0;
    int          last_acc = 0;
    int          prev_acc = 0;
    logic        chk_en = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_left <= 0;
            m_bin  <= '0;
            m_err  <= 1'b0;
        end else if (m_left == 0) begin
            if (start) begin
                m_pend   <= ref_conv(bcd);
                m_left   <= 5;
                prev_acc <= last_acc;
                last_acc <= cyc;
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) begin
                m_bin <= m_pend[13:0];
                m_err <= m_pend[14];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", 32'(busy), 32'(m_left > 0));
            chk("cyc_valid", 32'(bin_valid), 32'(m_left == 1));
            chk("cyc_bin", 32'(bin), 32'(m_bin));
            if (bin_valid) chk("cyc_err", 32'(err), 32'(m_err));
        end
    end

    task automatic pulse_start(input logic [15:0] v);
        @(negedge clk);
        bcd = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called on the negedge just after the accepting edge. Returns how many
    // cycles after the start cycle bin_valid was seen.
    task automatic wait_valid(output int lat);
        int n;
        n = 0;
        while (!bin_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("valid_seen", 32'(bin_valid), 32'd1);
        lat = n + 1;
    endtask

    initial begin
        int lat;
        int nv;
        logic [13:0] cap;

        // The model itself must agree with hand-worked conversions.
        chk("model_9999", 32'(ref_conv(16'h9999)), 32'h270F);
        chk("model_1234", 32'(ref_conv(16'h1234)), 32'h04D2);
        chk("model_12A4", 32'(ref_conv(16'h12A4)), 32'h4000);

        // A start held high during reset must be ignored.
        start = 1'b1;
        bcd = 16'h9999;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(bin_valid), 32'd0);
        chk("rst_bin", 32'(bin), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        chk("rst_start_ignored", 32'(busy), 32'd0);

        // 9999 full scale; result five cycles after the start cycle.
        pulse_start(16'h9999);
        wait_valid(lat);
        chk("lat_9999", 32'(lat), 32'd5);
        chk("bin_9999", 32'(bin), 32'h270F);
        chk("err_9999", 32'(err), 32'd0);

        // 1234, then 0000 issued back to back in the first idle cycle.
        pulse_start(16'h1234);
        wait_valid(lat);
        chk("bin_1234", 32'(bin), 32'h04D2);
        pulse_start(16'h0000);
        chk("b2b_accepted", 32'(busy), 32'd1);
        chk("b2b_spacing", 32'(last_acc - prev_acc), 32'd6);
        wait_valid(lat);
        chk("bin_0000", 32'(bin), 32'd0);
        chk("err_0000", 32'(err), 32'd0);

        // An illegal digit forces err and a zero result; the next request recovers.
        pulse_start(16'h12A4);
        wait_valid(lat);
        chk("err_12A4", 32'(err), 32'd1);
        chk("bin_12A4", 32'(bin), 32'd0);
        @(negedge clk);
        pulse_start(16'h0042);
        wait_valid(lat);
        chk("err_0042", 32'(err), 32'd0);
        chk("bin_0042", 32'(bin), 32'd42);

        // Start re-pulsed with another operand while busy is ignored.
        @(negedge clk);
        pulse_start(16'h5678);
        nv = 0;
        cap = '0;
        for (int i = 0; i < 12; i++) begin
            if (bin_valid) begin
                nv++;
                cap = bin;
            end
            if (i == 1) begin
                start = 1'b1;
                bcd = 16'h1111;
            end
            if (i == 3) start = 1'b0;
            @(negedge clk);
        end
        chk("busy_pulses", 32'(nv), 32'd1);
        chk("busy_bin", 32'(cap), 32'd5678);

        // Reset during the second CONV cycle aborts the conversion silently.
        pulse_start(16'h0999);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bin", 32'(bin), 32'd0);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            if (bin_valid) nv++;
            @(negedge clk);
        end
        chk("abort_no_valid", 32'(nv), 32'd0);
        pulse_start(16'h0500);
        wait_valid(lat);
        chk("bin_0500", 32'(bin), 32'd500);

        // Single-digit instance: result two cycles after the start cycle.
        @(negedge clk);
        s_bcd = 4'h7;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        chk("n1_busy", 32'(s_busy), 32'd1);
        chk("n1_valid_early", 32'(s_bin_valid), 32'd0);
        @(negedge clk);
        chk("n1_valid", 32'(s_bin_valid), 32'd1);
        chk("n1_bin", 32'(s_bin), 32'd7);
        chk("n1_err", 32'(s_err), 32'd0);
        @(negedge clk);
        chk("n1_idle", 32'(s_busy), 32'd0);
        s_bcd = 4'hC;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        @(negedge clk);
        chk("n1_err_valid", 32'(s_bin_valid), 32'd1);
        chk("n1_err_flag", 32'(s_err), 32'd1);
        chk("n1_err_bin", 32'(s_bin), 32'd0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_seq.md
BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

Interface
REQ-001 The block SHALL have parameter NDIG, default 4: number of packed BCD digits converted per request; legal range 1..9.
REQ-002 The block SHALL have parameter BW, default 14: binary result width; BW SHALL be at least ceil(log2(10^NDIG)); 14 for NDIG=4.
REQ-003 The block SHALL have port clk, input, width 1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, width 1: request pulse, sampled only while idle.
REQ-006 The block SHALL have port bcd, input, width 4*NDIG: packed BCD operand; digit 0 (least significant) in bits [3:0].
REQ-007 The block SHALL have port busy, output, width 1: high while a conversion is in progress.
REQ-008 The block SHALL have port bin, output, width BW: binary result, held stable until the next accepted request.
REQ-009 The block SHALL have port bin_valid, output, width 1: one-cycle pulse marking a new result on bin.
REQ-010 The block SHALL have port err, output, width 1: qualified by bin_valid; high when any digit of the operand exceeded 9.

Function
REQ-011 The block SHALL implement the FSM states IDLE, CONV and DONE.
REQ-012 In IDLE with start=1 at a rising edge, the block SHALL latch bcd into an internal operand register, clear the accumulator, clear the error flag, load the digit counter with NDIG-1, and enter CONV.
REQ-013 Each CONV cycle SHALL process one digit, most significant digit first, as acc <= acc*10 + digit; the multiply SHALL be formed as (acc<<3)+(acc<<1), with no multiplier inferred.
REQ-014 The accumulator SHALL be BW bits wide; the intermediate sum SHALL be computed at BW+4 bits and truncated to BW bits, so no overflow is possible for legal BW.
REQ-015 Any processed digit greater than 9 SHALL set the sticky error flag; that digit's raw value SHALL still be accumulated.
REQ-016 After the digit with counter value 0 is processed, the block SHALL enter DONE, load bin from the final accumulator value (0 if the error flag is set), and drive err from the error flag.
REQ-017 bin_valid SHALL be 1 exactly during the DONE cycle; DONE SHALL return to IDLE unconditionally on the next edge.
REQ-018 The latency SHALL be NDIG+1 cycles: with start sampled at edge k, bin_valid is high in the cycle following edge k+NDIG.
REQ-019 busy SHALL be 1 in the CONV and DONE states and 0 in IDLE.
REQ-020 start SHALL be ignored in CONV and DONE; the operand register SHALL be unaffected by changes on bcd after acceptance.
REQ-021 The minimum request spacing SHALL be NDIG+2 cycles; start asserted in the first IDLE cycle after DONE SHALL be accepted.
REQ-022 err SHALL hold its last value between bin_valid pulses; it is meaningful only when bin_valid=1.
REQ-023 The block SHALL accept and convert NDIG=1 correctly, passing through a single CONV cycle.

Reset
REQ-024 With rst=1 at an edge, the block SHALL set state=IDLE, busy=0, bin_valid=0, bin=0, err=0, and clear the accumulator, counter and operand register.
REQ-025 rst SHALL take priority over start and over any in-progress conversion; a conversion aborted by rst SHALL produce no bin_valid pulse.
REQ-026 start high during the rst cycle SHALL be ignored; the first request can be accepted on the edge after rst deasserts.

Verification (NDIG=4, BW=14)
REQ-027 The bench SHALL check: bcd=16'h9999, start pulse -> bin_valid exactly 5 cycles later, bin=14'd9999 (0x270F), err=0.
REQ-028 The bench SHALL check: bcd=16'h1234 -> bin=0x04D2; then bcd=16'h0000 issued on the first idle cycle -> bin=0, err=0, back-to-back spacing of 6 cycles.
REQ-029 The bench SHALL check: bcd=16'h12A4 -> bin_valid with err=1 and bin=0; a following request with bcd=16'h0042 -> err=0, bin=42.
REQ-030 The bench SHALL check: start re-pulsed with a different bcd during busy -> ignored; result matches the first operand, with exactly one bin_valid pulse.
REQ-031 The bench SHALL check: rst asserted on the second CONV cycle -> busy=0, bin=0, and no bin_valid pulse; a new request with 16'h0500 -> bin=500.
REQ-032 The bench SHALL check: NDIG=1, BW=4, bcd=4'h7 -> bin=7 two cycles after start.
